// File: rtl/node_if_pkg.sv
// Shared widths, offer-state encoding and counter helpers for the node port.
package node_if_pkg;

    localparam int PKT_FROM_NODE_W = 29;
    localparam int PKT_TO_NODE_W   = 24;
    localparam int CNT_W           = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } offer_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/node_port_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and registered flags.
// Pushes into a full FIFO and pops from an empty FIFO are ignored; fullness
// and emptiness are judged on the state before the current edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_r;
    logic             empty_r;

    logic             do_push_s;
    logic             do_pop_s;
    logic [AW:0]      count_nxt_s;

    assign do_push_s   = push && !full_r;
    assign do_pop_s    = pop && !empty_r;
    assign count_nxt_s = count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);

    assign full  = full_r;
    assign empty = empty_r;
    assign head  = mem_r[rd_ptr_r];

    // Storage array; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy (one extra bit) and the registered full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == (AW+1)'(DEPTH));
            empty_r <= (count_nxt_s == (AW+1)'(1'b0));
        end
    end

endmodule

// File: rtl/node_port.sv
// Node-side endpoint of the router core: outbound FIFO feeding a
// three-state offer machine, inbound FIFO for deliveries, and saturating
// traffic/drop counters.
module node_port
    import node_if_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                       Clk_R,
    input  logic                       Rst_n,
    input  logic                       Host_Wr_En,
    input  logic [PKT_FROM_NODE_W-1:0] Host_Wr_Data,
    output logic                       Host_Full,
    input  logic                       Host_Rd_En,
    output logic [PKT_TO_NODE_W-1:0]   Host_Rd_Data,
    output logic                       Host_Empty,
    output logic [PKT_FROM_NODE_W-1:0] Packet_From_Node,
    output logic                       Packet_From_Node_Valid,
    input  logic                       Core_Load_Ack,
    input  logic [PKT_TO_NODE_W-1:0]   Packet_To_Node,
    input  logic                       Packet_To_Node_Valid,
    output logic [CNT_W-1:0]           Tx_Count,
    output logic [CNT_W-1:0]           Rx_Count,
    output logic [CNT_W-1:0]           Drop_Count
);

    offer_state_e               state_r;
    logic                       valid_r;
    logic [PKT_FROM_NODE_W-1:0] pkt_r;
    logic [CNT_W-1:0]           tx_cnt_r;
    logic [CNT_W-1:0]           rx_cnt_r;
    logic [CNT_W-1:0]           drop_cnt_r;

    logic                       tx_empty_s;
    logic                       tx_pop_s;
    logic [PKT_FROM_NODE_W-1:0] tx_head_s;
    logic                       rx_full_s;
    logic                       tx_ack_s;
    logic                       rx_accept_s;
    logic                       rx_drop_s;

    // The offer machine takes the head only while idle; the head then lives
    // in pkt_r, freeing its FIFO slot for the host.
    assign tx_pop_s    = (state_r == IDLE) && !tx_empty_s;
    assign tx_ack_s    = (state_r == OFFER) && Core_Load_Ack;
    assign rx_accept_s = Packet_To_Node_Valid && !rx_full_s;
    assign rx_drop_s   = Packet_To_Node_Valid && rx_full_s;

    sync_fifo #(
        .WIDTH (PKT_FROM_NODE_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (Clk_R),
        .rst_n (Rst_n),
        .push  (Host_Wr_En),
        .din   (Host_Wr_Data),
        .pop   (tx_pop_s),
        .full  (Host_Full),
        .empty (tx_empty_s),
        .head  (tx_head_s)
    );

    sync_fifo #(
        .WIDTH (PKT_TO_NODE_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (Clk_R),
        .rst_n (Rst_n),
        .push  (Packet_To_Node_Valid),
        .din   (Packet_To_Node),
        .pop   (Host_Rd_En),
        .full  (rx_full_s),
        .empty (Host_Empty),
        .head  (Host_Rd_Data)
    );

    // Offer FSM: load head, hold until acked, then force one idle gap cycle.
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            pkt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!tx_empty_s) begin
                        pkt_r   <= tx_head_s;
                        valid_r <= 1'b1;
                        state_r <= OFFER;
                    end
                end
                OFFER: begin
                    if (Core_Load_Ack) begin
                        valid_r <= 1'b0;
                        state_r <= GAP;
                    end
                end
                GAP: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Saturating traffic and drop counters.
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_cnt_r   <= '0;
            rx_cnt_r   <= '0;
            drop_cnt_r <= '0;
        end else begin
            if (tx_ack_s) begin
                tx_cnt_r <= sat_inc(tx_cnt_r);
            end
            if (rx_accept_s) begin
                rx_cnt_r <= sat_inc(rx_cnt_r);
            end
            if (rx_drop_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
        end
    end

    assign Packet_From_Node       = pkt_r;
    assign Packet_From_Node_Valid = valid_r;
    assign Tx_Count               = tx_cnt_r;
    assign Rx_Count               = rx_cnt_r;
    assign Drop_Count             = drop_cnt_r;

endmodule
